apb_requester_engine: RTL and testbench
=======================================

Name: apb_requester_engine

Overview:
Single-outstanding APB requester (initiator) for the management bus, driving 16-bit completers such as the system-info/health register block. It converts a simple valid/ready command port (address, read/write, write data) into APB SETUP/ACCESS phases and returns read data and error status on a one-cycle response strobe. It is used by management-side logic (sensor pollers, the debug bridge) that must read idcode, serial and sensor registers without a CPU.

Parameters:
ADDR_WIDTH, 8, width of paddr and req_addr
DATA_WIDTH, 16, width of pwdata/prdata; only 16 supported, any other value is a synthesis error
TIMEOUT_CYCLES, 255, max ACCESS-phase cycles without pready before abort (timeout build only); must be >= 1

Ports:
clk  in  1  bus clock; also drives completer pclk
rst  in  1  synchronous active-high reset
req_valid  in  1  command valid
req_ready  out  1  engine can accept a command this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  one-cycle completion strobe
resp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
resp_err  out  1  completer pslverr, or timeout
resp_timeout  out  1  completion was a timeout abort
apb_psel  out  1  APB select
apb_penable  out  1  APB enable
apb_pwrite  out  1  APB direction
apb_paddr  out  ADDR_WIDTH  APB address
apb_pwdata  out  DATA_WIDTH  APB write data
apb_prdata  in  DATA_WIDTH  APB read data
apb_pready  in  1  APB ready
apb_pslverr  in  1  APB error

Behaviour:
- Single clock clk; reset synchronous, active-high, named rst.
- Reset values: all outputs 0 except req_ready=1; state IDLE.
- States: IDLE, SETUP, ACCESS.
- IDLE: req_ready=1 (combinational from state). On req_valid&&req_ready, register addr/write/wdata onto apb_paddr/apb_pwrite/apb_pwdata; psel=1, penable=0 next cycle; go SETUP.
- SETUP: exactly one cycle; next cycle penable=1; go ACCESS. req_ready=0.
- ACCESS: psel=penable=1; paddr/pwrite/pwdata held stable for every wait cycle. On pready sampled high: next cycle psel=penable=0, resp_valid=1, resp_rdata=prdata if read (else 0), resp_err=pslverr, resp_timeout=0; go IDLE.
- Latency: command accepted at edge N -> SETUP at N+1, ACCESS at N+2, zero-wait completion resp_valid at N+3.
- resp_valid is a single-cycle pulse with no backpressure; resp_rdata/resp_err/resp_timeout valid only while it is high and zeroed otherwise.
- Back-to-back: req_ready is high in the cycle resp_valid is high, so a new command may be accepted then. The minimum command-to-command spacing is 3 cycles.
- apb_paddr/apb_pwdata/apb_pwrite keep their last values in IDLE. psel is never asserted without a registered command.
- pready/pslverr/prdata are ignored outside ACCESS.
- Reset in any state: next edge psel=penable=0, IDLE, no resp_valid for the aborted transfer.
- No address-alignment checking; odd addresses are passed through and the completer's error is reported.

Optional Feature:
APB_REQUESTER_TIMEOUT_EN
- Defined: counter of $clog2(TIMEOUT_CYCLES+1) bits cleared on SETUP->ACCESS and incremented each ACCESS cycle with pready low. When the count reaches TIMEOUT_CYCLES with pready still low: next cycle psel=penable=0, resp_valid=1, resp_err=1, resp_timeout=1, resp_rdata=0, IDLE. If pready is high in the same cycle the limit is reached, a normal completion wins.
- Undefined: no counter; ACCESS waits for pready indefinitely; resp_timeout tied 0.

Test Plan:
- Read 0x00, completer zero-wait with prdata=0x3631, pslverr=0 -> psel at N+1, penable at N+2, resp_valid at N+3 with rdata=0x3631, err=0.
- Write 0x10 data 0xBEEF, completer pslverr=1 (read-only) -> pwrite=1 and pwdata=0xBEEF during SETUP/ACCESS; resp_err=1, resp_rdata=0.
- Read 0x14, pready held low 3 ACCESS cycles then high with prdata=0x9A40 -> paddr/penable stable for 4 ACCESS cycles; resp_valid exactly once with 0x9A40.
- Back-to-back reads 0x04 then 0x06, req_valid held high -> second accepted in the resp_valid cycle of the first; second psel rises 3 cycles after first.
- Timeout build, TIMEOUT_CYCLES=4, pready never asserted -> after 4 ACCESS cycles psel drops, resp_err=1, resp_timeout=1. Non-timeout build: psel still high after 1000 cycles.
- rst asserted for one cycle during ACCESS -> psel=penable=0 next edge, no resp_valid, req_ready=1, and a subsequent read of 0x00 completes normally.

Source files
------------

// File: rtl/apb_requester_engine_if.sv
// Command/response and APB bus bundle for apb_requester_engine.
// The master modport is the requester's view; slave is the view of the surrounding logic.
interface apb_requester_engine_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  resp_timeout;
  logic                  apb_psel;
  logic                  apb_penable;
  logic                  apb_pwrite;
  logic [ADDR_WIDTH-1:0] apb_paddr;
  logic [DATA_WIDTH-1:0] apb_pwdata;
  logic [DATA_WIDTH-1:0] apb_prdata;
  logic                  apb_pready;
  logic                  apb_pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  apb_prdata, apb_pready, apb_pslverr,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output apb_prdata, apb_pready, apb_pslverr,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
  );
endinterface

// File: rtl/apb_requester_engine.sv
// Single-outstanding APB requester: one valid/ready command -> one SETUP/ACCESS transfer.
// Define APB_REQUESTER_TIMEOUT_EN to abort ACCESS phases that wait too long for pready.
module apb_requester_engine #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    rst,
  apb_requester_engine_if.master bus
);

  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("apb_requester_engine: only DATA_WIDTH = 16 is supported");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester_engine: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  resp_timeout_q;
  logic                  timeout_hit;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Counts ACCESS cycles that ended without pready; the last allowed one aborts.
  always_ff @(posedge clk) begin
    if (rst || state_q == StSetup) begin
      cnt_q <= '0;
    end else if (state_q == StAccess && !bus.apb_pready) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign timeout_hit = (state_q == StAccess) && !bus.apb_pready && (cnt_q == CntLast);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_wdata;
            psel_q   <= 1'b1;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (bus.apb_pready || timeout_hit) begin
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StIdle;
            // A completion in the limit cycle wins over the timeout.
            if (bus.apb_pready) begin
              resp_err_q   <= bus.apb_pslverr;
              resp_rdata_q <= (!pwrite_q && !bus.apb_pslverr) ? bus.apb_prdata : '0;
            end else begin
              resp_err_q     <= 1'b1;
              resp_timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.apb_psel     = psel_q;
  assign bus.apb_penable  = penable_q;
  assign bus.apb_pwrite   = pwrite_q;
  assign bus.apb_paddr    = paddr_q;
  assign bus.apb_pwdata   = pwdata_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_apb_requester_engine.sv
// Randomized scoreboard bench for apb_requester_engine with a scripted APB completer.
// Follows APB_REQUESTER_TIMEOUT_EN so the same bench covers both builds.
module tb_apb_requester_engine;
  localparam int TO = 4;
`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
    int          waits;
    logic        e;
    logic [15:0] rd;
    int          acc;
  } plan_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  plan_t plan_q[$];
  resp_t exp_q[$];

  apb_requester_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  apb_requester_engine #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response straight from the transfer rules: waits, error and timeout limit.
  function automatic resp_t model(input plan_t p);
    resp_t r;
    r.to    = TO_EN && (p.waits >= TO);
    r.err   = r.to || p.e;
    r.rdata = (!p.w && !r.err) ? p.rd : 16'h0;
    r.cyc   = r.to ? p.acc + 2 + TO : p.acc + 3 + p.waits;
    return r;
  endfunction

  task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input int waits, input logic e, input logic [15:0] rd,
                       input bit keep, output int acc);
    plan_t p;
    int    n;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      step();
      n++;
    end
    acc = -1;
    if (!bus.req_ready) begin
      chk("accept_bound", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    acc     = cyc;
    p.w     = w;
    p.a     = a;
    p.d     = d;
    p.waits = waits;
    p.e     = e;
    p.rd    = rd;
    p.acc   = acc;
    plan_q.push_back(p);
    exp_q.push_back(model(p));
    step();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_psel", 32'(bus.apb_psel), 32'd0);
    chk("rst_penable", 32'(bus.apb_penable), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  // Response monitor / scoreboard.
  initial begin
    resp_t r;
    forever begin
      step();
      if (bus.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("resp_rdata", 32'(bus.resp_rdata), 32'(r.rdata));
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_timeout", 32'(bus.resp_timeout), 32'(r.to));
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("ready_in_resp", 32'(bus.req_ready), 32'd1);
        end
      end else if (!rst) begin
        chk("idle_resp_zero", {15'd0, bus.resp_rdata, bus.resp_err}, 32'd0);
        chk("idle_timeout_zero", 32'(bus.resp_timeout), 32'd0);
      end
    end
  end

  // APB completer: follows the plan for each transfer, drives junk outside ACCESS.
  initial begin
    plan_t cur;
    int    left;
    bit    have;
    bit    first;
    have = 1'b0;
    first = 1'b0;
    left = 0;
    bus.apb_pready  = 1'b0;
    bus.apb_pslverr = 1'b0;
    bus.apb_prdata  = 16'h0;
    forever begin
      step();
      bus.apb_pready  = 1'($urandom_range(0, 1));
      bus.apb_pslverr = 1'($urandom_range(0, 1));
      bus.apb_prdata  = 16'($urandom);
      if (!bus.apb_psel) have = 1'b0;
      if (bus.apb_penable && !bus.apb_psel) chk("penable_without_psel", 32'd1, 32'd0);
      if (bus.apb_psel && !bus.apb_penable) begin
        if (plan_q.size() == 0) begin
          chk("psel_without_cmd", 32'd1, 32'd0);
        end else begin
          cur   = plan_q.pop_front();
          have  = 1'b1;
          first = 1'b1;
          left  = cur.waits;
          chk("setup_cycle", 32'(cyc), 32'(cur.acc + 1));
          chk("setup_paddr", 32'(bus.apb_paddr), 32'(cur.a));
          chk("setup_pwrite", 32'(bus.apb_pwrite), 32'(cur.w));
          chk("setup_pwdata", 32'(bus.apb_pwdata), 32'(cur.d));
        end
      end else if (bus.apb_psel && bus.apb_penable && have) begin
        if (first) chk("access_cycle", 32'(cyc), 32'(cur.acc + 2));
        first = 1'b0;
        chk("access_stable", {7'd0, bus.apb_pwrite, bus.apb_paddr, bus.apb_pwdata},
            {7'd0, cur.w, cur.a, cur.d});
        if (left == 0) begin
          bus.apb_pready  = 1'b1;
          bus.apb_pslverr = cur.e;
          bus.apb_prdata  = cur.e ? 16'h0 : cur.rd;
        end else begin
          bus.apb_pready = 1'b0;
          left--;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int a1;
    int a2;
    int n;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h0;
    bus.req_wdata = 16'h0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_outputs", {bus.apb_psel, bus.apb_penable, bus.apb_pwrite, bus.resp_valid,
                          bus.resp_err, bus.resp_timeout, bus.apb_paddr, bus.apb_pwdata}, 32'd0);
    chk("reset_rdata", 32'(bus.resp_rdata), 32'd0);
    rst = 1'b0;
    step();

    issue(1'b0, 8'h00, 16'h0000, 0, 1'b0, 16'h3631, 1'b0, a1);
    drain();
    issue(1'b1, 8'h10, 16'hBEEF, 0, 1'b1, 16'h0000, 1'b0, a1);
    drain();
    issue(1'b0, 8'h14, 16'h0000, 3, 1'b0, 16'h9A40, 1'b0, a1);
    drain();

    issue(1'b0, 8'h04, 16'h0000, 0, 1'b0, 16'h1111, 1'b1, a1);
    issue(1'b0, 8'h06, 16'h0000, 0, 1'b0, 16'h2222, 1'b0, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd3);
    drain();

    for (int i = 0; i < 40; i++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      issue(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
            int'($urandom_range(0, TO_EN ? 6 : 5)), ($urandom_range(0, 3) == 0),
            16'($urandom), keep, a1);
      if (!keep) repeat ($urandom_range(0, 2)) step();
    end
    bus.req_valid = 1'b0;
    drain();

    // Completer that never answers.
    issue(1'b0, 8'h20, 16'h0000, 100000, 1'b0, 16'h5555, 1'b0, a1);
    if (TO_EN) begin
      drain();
      chk("timeout_psel_low", 32'(bus.apb_psel), 32'd0);
    end else begin
      repeat (1000) step();
      chk("hang_psel_penable", {30'd0, bus.apb_psel, bus.apb_penable}, 32'd3);
      pulse_reset();
      void'(exp_q.pop_back());
    end

    // Reset in the middle of an ACCESS wait, then a normal read.
    issue(1'b0, 8'h14, 16'h0000, 10, 1'b0, 16'hAAAA, 1'b0, a1);
    n = 0;
    while (!(bus.apb_psel && bus.apb_penable) && n < 20) begin
      step();
      n++;
    end
    chk("reach_access", {30'd0, bus.apb_psel, bus.apb_penable}, 32'd3);
    pulse_reset();
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (5) step();
    issue(1'b0, 8'h00, 16'h0000, 0, 1'b0, 16'h3631, 1'b0, a1);
    drain();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
